// File: rtl/nibble_pkg.sv
// Shared constants and FSM encoding for the nibble playback block.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw button.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, primed_q, armed_q, pulse_q;

  // armed_q only sets once a genuine low sample has been seen after reset,
  // so a button already held through reset cannot fake a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      primed_q <= 1'b1;
      armed_q  <= armed_q | (primed_q & ~sync1_q);
      pulse_q  <= armed_q & sync1_q & ~sync2_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/nibble_player.sv
// Plays an N-bit word MSB-first on two LEDs, each bit shown then blanked.
module nibble_player
  import nibble_pkg::*;
#(
  parameter int N          = NIBBLE_W,
  parameter int BIT_CYCLES = 100000000,
  parameter int GAP_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] bus_in,
  output logic         led_zero,
  output logic         led_one,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(max_int(BIT_CYCLES, GAP_CYCLES)) + 1;
  localparam int RW = $clog2(N + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] REM_INIT = RW'(N);

  logic           pulse;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic           led_zero_q, led_zero_d;
  logic           led_one_q, led_one_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  button_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (start),
    .pulse (pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      shadow_q   <= '0;
      led_zero_q <= 1'b0;
      led_one_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      shadow_q   <= shadow_d;
      led_zero_q <= led_zero_d;
      led_one_q  <= led_one_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A pulse landing on the done cycle is dropped; a fresh press is needed.
        if (pulse && !done_q) begin
          shadow_d = bus_in;
          rem_d    = REM_INIT;
          cnt_d    = '0;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          shadow_d = {shadow_q[N-2:0], 1'b0};
          rem_d    = rem_q - 1'b1;
          state_d  = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rem_q != '0) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from next state so they align with the state.
    led_one_d  = (state_d == ST_SHOW) &  shadow_d[N-1];
    led_zero_d = (state_d == ST_SHOW) & ~shadow_d[N-1];
    busy_d     = (state_d != ST_IDLE);
  end

  assign led_zero = led_zero_q;
  assign led_one  = led_one_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nibble_player.sv
// Self-checking bench for nibble_player with a per-cycle playback reference model.
module tb_nibble_player;

  localparam int N = 4;
  localparam int B = 4;
  localparam int G = 2;
  localparam int T = N * (B + G);
  localparam int NONE = -100;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] bus_in;
  logic         led_zero, led_one, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  nibble_player #(.N(N), .BIT_CYCLES(B), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus_in   (bus_in),
    .led_zero (led_zero),
    .led_one  (led_one),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected {led_zero, led_one, busy, done} k cycles after SHOW is entered.
  function automatic logic [3:0] model(input int k, input logic [N-1:0] b);
    int bi, ph;
    logic bt;
    if (k < 0) return 4'b0000;
    if (k < T) begin
      bi = k / (B + G);
      ph = k % (B + G);
      if (ph < B) begin
        bt = b[N-1-bi];
        return {~bt, bt, 1'b1, 1'b0};
      end
      return 4'b0010;
    end
    if (k == T) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int n, input string nm);
    logic [3:0] act;
    for (int i = 0; i < n; i++) begin
      step();
      act = {led_zero, led_one, busy, done};
      n_chk++;
      if (act !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: got %b expected 0000", nm, i, act);
      end
    end
  endtask

  // Raises start, then checks every cycle of the playback against the model.
  task automatic press_and_check(input logic [N-1:0] bits, input int hold,
                                 input int chg_k, input logic [N-1:0] chg_val,
                                 input int press_k, input int rel_k,
                                 input int stop_k, input string nm);
    logic [3:0] act, exp;
    int k;
    bus_in = bits;
    start  = 1'b1;
    for (int c = 1; c <= T + 4; c++) begin
      step();
      k   = c - 3;
      exp = model(k, bits);
      act = {led_zero, led_one, busy, done};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s c=%0d: got %b expected %b", nm, c, act, exp);
      end
      if (k == stop_k) return;
      if (hold > 0 && c == hold) start = 1'b0;
      if (k == chg_k) bus_in = chg_val;
      if (k == press_k) start = 1'b1;
      if (k == rel_k) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [3:0] act;
    reset = 1'b1; start = 1'b0; bus_in = '0;
    step(); step();
    act = {led_zero, led_one, busy, done};
    n_chk++;
    if (act !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0000", act);
    end
    reset = 1'b0;
    check_idle(4, "post_reset");
  endtask

  task automatic test_start_cycle0();
    press_and_check(4'b1010, 1, NONE, '0, NONE, NONE, NONE, "first_press_1010");
  endtask

  task automatic test_bus_change();
    press_and_check(4'b0000, 1, 1, 4'b1111, NONE, NONE, NONE, "bus_change");
    check_idle(3, "bus_change_idle");
  endtask

  task automatic test_ignore_busy();
    press_and_check(4'b0110, 2, NONE, '0, 9, 11, NONE, "press_while_busy");
    check_idle(6, "press_while_busy_idle");
  endtask

  task automatic test_reset_mid();
    logic [3:0] act;
    press_and_check(4'b1101, 1, NONE, '0, NONE, NONE, B + G + 1, "reset_mid_pre");
    reset = 1'b1;
    #1;
    act = {led_zero, led_one, busy, done};
    n_chk++;
    if (act !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected 0000", act);
    end
    step();
    reset = 1'b0;
    bus_in = 4'b1001;
    check_idle(5, "reset_mid_nodone");
    press_and_check(4'b1001, 1, NONE, '0, NONE, NONE, NONE, "reset_mid_replay");
  endtask

  task automatic test_held();
    press_and_check(4'b0011, 0, NONE, '0, NONE, NONE, NONE, "held_100");
    check_idle(100 - (T + 4), "held_100_idle");
    start = 1'b0;
    check_idle(4, "held_100_release");
  endtask

  task automatic test_glitch();
    press_and_check(4'b1100, 2, NONE, '0, NONE, NONE, NONE, "glitch_2cyc");
    check_idle(4, "glitch_idle");
  endtask

  task automatic test_done_edge();
    press_and_check(4'b0101, 1, NONE, '0, T - 2, NONE, NONE, "edge_on_done");
    check_idle(10, "edge_on_done_idle");
    start = 1'b0;
    check_idle(4, "edge_on_done_release");
  endtask

  task automatic test_held_through_reset();
    start = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle(20, "held_through_reset");
    start = 1'b0;
    check_idle(4, "held_through_reset_release");
    press_and_check(4'b1110, 1, NONE, '0, NONE, NONE, NONE, "after_held_reset");
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int h;
    for (int i = 0; i < 6; i++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      h = $urandom_range(1, 5);
      press_and_check(v, h, NONE, '0, NONE, NONE, NONE, "random");
      check_idle($urandom_range(2, 6), "random_idle");
    end
  endtask

  initial begin
    test_reset();
    test_start_cycle0();
    check_idle(3, "gap0");
    test_bus_change();
    test_ignore_busy();
    test_reset_mid();
    check_idle(3, "gap1");
    test_held();
    test_glitch();
    test_done_edge();
    test_held_through_reset();
    check_idle(3, "gap2");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
